// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int COMMON_WIDTH = 32;

    // Bubble address the PC register presents out of reset; never fetched.
    localparam logic [COMMON_WIDTH-1:0] RESET_PC = 32'hFFFF_FFFC;

    // Entry handed to decode: instruction word paired with its PC.
    typedef struct packed {
        logic [COMMON_WIDTH-1:0] pc;
        logic [COMMON_WIDTH-1:0] inst;
    } fetch_entry_t;

    // In-flight request: PC plus the flush epoch it was issued under.
    typedef struct packed {
        logic [COMMON_WIDTH-1:0] pc;
        logic                    epoch;
    } pending_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count and synchronous clear.
// Latency: a push is visible at the head on the next cycle; the head is zero when empty.
// Backpressure: none internally; push when full / pop when empty are ignored, callers budget space.
module sync_fifo #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_dat,
    input  logic          pop,
    input  logic          clear,
    output T              head,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // Pointers and count; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_dat;
    end

    assign head = (count != '0) ? mem[rd_ptr] : T'('0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch responder: issues in-order imem requests for the PC stream and pairs words with their PCs for decode.
// Latency: PC accepted at T0 with memory latency L reaches decode at T0+L+1; no response-to-decode bypass.
// Backpressure: credit-limited requests (outstanding + buffered <= DEPTH) drive stall; jump flushes via epoch.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      DEPTH    = 4,
    parameter logic [COMMON_WIDTH-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [COMMON_WIDTH-1:0] pc_addr,
    input  logic                    jump,
    output logic                    stall,
    output logic                    imem_req_valid,
    output logic [COMMON_WIDTH-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_resp_valid,
    input  logic [COMMON_WIDTH-1:0] imem_resp_data,
    output logic                    if_valid,
    output logic [COMMON_WIDTH-1:0] if_pc,
    output logic [COMMON_WIDTH-1:0] if_inst,
    input  logic                    if_ready
);

    localparam int            CW     = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_U = (CW + 1)'(DEPTH);

    logic           epoch;
    pending_entry_t pend_head;
    logic [CW-1:0]  pend_count;
    fetch_entry_t   out_head;
    logic [CW-1:0]  out_count;
    logic [CW:0]    used;
    logic           has_credit;
    logic           pc_live;
    logic           req_fire;
    logic           resp_keep;

    // Every in-flight request already owns an output slot, so responses never need back-pressure.
    assign used       = {1'b0, pend_count} + {1'b0, out_count};
    assign has_credit = used < DEPTH_U;

    // rst is folded in so request/stall drop the instant reset asserts, whatever pc_addr shows.
    assign pc_live        = rst && (pc_addr != RESET_PC) && !jump;
    assign imem_req_valid = pc_live && has_credit;
    assign imem_req_addr  = pc_addr;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign stall          = pc_live && !req_fire;

    // Responses issued before the latest jump carry the old epoch and are dropped.
    assign resp_keep = imem_resp_valid && (pend_head.epoch == epoch) && !jump;

    assign if_valid = (out_count != '0) && !jump;
    assign if_pc    = out_head.pc;
    assign if_inst  = out_head.inst;

    // Each jump opens a new epoch; older in-flight responses become wrong-path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) epoch <= 1'b0;
        else if (jump) epoch <= ~epoch;
    end

    // In-flight requests; its occupancy is the outstanding count. Never flushed.
    sync_fifo #(
        .T     (pending_entry_t),
        .DEPTH (DEPTH)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .push     (req_fire),
        .push_dat ('{pc: pc_addr, epoch: epoch}),
        .pop      (imem_resp_valid),
        .clear    (1'b0),
        .head     (pend_head),
        .count    (pend_count)
    );

    // Decode-side buffer; emptied on jump.
    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .push     (resp_keep),
        .push_dat ('{pc: pend_head.pc, inst: imem_resp_data}),
        .pop      (if_valid && if_ready),
        .clear    (jump),
        .head     (out_head),
        .count    (out_count)
    );

endmodule
